// File: rtl/lut_ff_mux_bist_pkg.sv
// Shared constants for the lut_ff_mux self-test: FSM encoding, result codes and
// the golden LUT truth table of the cell under test.
package lut_ff_mux_bist_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RSTCHK = 2'd1;
  localparam logic [1:0] ST_VEC    = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [5:0] FAIL_NONE = 6'd63;
  localparam logic [5:0] FAIL_RST  = 6'd32;
  localparam int         NUM_VEC   = 32;

  localparam logic [15:0] EXP_TABLE_DFLT = 16'h6676;

  // Vector v drives input v[4:1]; odd vectors use mux_sel=0, which inverts Q.
  function automatic logic exp_q(input logic [15:0] tbl, input logic [4:0] v);
    return tbl[v[4:1]] ^ v[0];
  endfunction

endpackage

// File: rtl/lut_ff_mux_bist_timer.sv
// Loadable down-counter; tick_o is high while the count sits at zero.
// A load of N produces tick_o on the (N+1)th cycle after the load edge.
module lut_ff_mux_bist_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/lut_ff_mux_bist.sv
// BIST driver/checker for lut_ff_mux: reset check then 32 LUT/mux vectors.
// done rises RST_CYCLES + 32*SETTLE cycles after the start edge; start is ignored while busy.
module lut_ff_mux_bist
  import lut_ff_mux_bist_pkg::*;
#(
  parameter int          SETTLE     = 10,
  parameter int          RST_CYCLES = 10,
  parameter logic [15:0] EXP_TABLE  = EXP_TABLE_DFLT,
  parameter int          ERR_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [5:0]       first_fail,
  output logic [3:0]       dut_in,
  output logic             dut_mux_sel,
  output logic             dut_rst,
  input  logic             dut_q
);

  localparam int MAXC  = (SETTLE > RST_CYCLES) ? SETTLE : RST_CYCLES;
  localparam int CNT_W = $clog2(MAXC);
  localparam logic [CNT_W-1:0] LD_RST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_VEC = CNT_W'(SETTLE - 1);

  logic [1:0]       state_q, state_d;
  logic [4:0]       vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [5:0]       ff_q, ff_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [3:0]       din_q, din_d;
  logic             sel_q, sel_d;
  logic             drst_q, drst_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tick;
  logic [4:0]       vec_nxt;
  logic [ERR_W-1:0] err_sat;
  logic             exp_bit;

  lut_ff_mux_bist_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tick_o     (tick)
  );

  assign vec_nxt = vec_q + 5'd1;
  assign err_sat = (&err_q) ? err_q : err_q + 1'b1;
  assign exp_bit = exp_q(EXP_TABLE, vec_q);

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    err_d    = err_q;
    ff_d     = ff_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    din_d    = din_q;
    sel_d    = sel_q;
    drst_d   = drst_q;
    tmr_load = 1'b0;
    tmr_val  = LD_RST;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RSTCHK;
          err_d    = '0;
          ff_d     = FAIL_NONE;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          din_d    = 4'd0;
          sel_d    = 1'b1;
          drst_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = LD_RST;
        end
      end
      ST_RSTCHK: begin
        if (tick) begin
          // Case-equality so an X/Z on dut_q is a mismatch.
          if (dut_q !== 1'b0) begin
            err_d = err_sat;
            if (ff_q == FAIL_NONE) ff_d = FAIL_RST;
          end
          state_d  = ST_VEC;
          vec_d    = 5'd0;
          din_d    = 4'd0;
          sel_d    = 1'b1;
          drst_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = LD_VEC;
        end
      end
      ST_VEC: begin
        if (tick) begin
          if (dut_q !== exp_bit) begin
            err_d = err_sat;
            if (ff_q == FAIL_NONE) ff_d = {1'b0, vec_q};
          end
          if (vec_q == 5'(NUM_VEC - 1)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
            din_d   = 4'd0;
            sel_d   = 1'b1;
            drst_d  = 1'b1;
          end else begin
            vec_d    = vec_nxt;
            din_d    = vec_nxt[4:1];
            sel_d    = ~vec_nxt[0];
            tmr_load = 1'b1;
            tmr_val  = LD_VEC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= 5'd0;
      err_q   <= '0;
      ff_q    <= FAIL_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      din_q   <= 4'd0;
      sel_q   <= 1'b1;
      drst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      din_q   <= din_d;
      sel_q   <= sel_d;
      drst_q  <= drst_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign first_fail  = ff_q;
  assign dut_in      = din_q;
  assign dut_mux_sel = sel_q;
  assign dut_rst     = drst_q;

endmodule

// File: tb/tb_lut_ff_mux_bist.sv
// Bench: behavioural lut_ff_mux cell with fault modes, reference result model,
// directed and randomized runs of the BIST.
module tb_lut_ff_mux_bist;

  localparam logic [15:0] EXP = 16'h6676;
  localparam int LAT = 10 + 32 * 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass;
  logic [5:0] err_count, first_fail;
  logic [3:0] dut_in;
  logic       dut_mux_sel, dut_rst, dut_q;

  logic       busy2, done2, pass2;
  logic [3:0] err2;
  logic [5:0] ff2;
  logic [3:0] din2;
  logic       sel2, drst2;

  int n_vec = 0;
  int n_err = 0;

  // Cell model: mode 0 = LUT from cell_tbl, 1 = Q stuck 0, 2 = Q stuck 1.
  int          cell_mode = 0;
  logic [15:0] cell_tbl  = EXP;
  logic        cell_ff   = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk)
    cell_ff <= dut_rst ? 1'b0 : (dut_mux_sel ? cell_tbl[dut_in] : ~cell_tbl[dut_in]);

  assign dut_q = (cell_mode == 1) ? 1'b0 : (cell_mode == 2) ? 1'b1 : cell_ff;

  lut_ff_mux_bist u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail), .dut_in(dut_in),
    .dut_mux_sel(dut_mux_sel), .dut_rst(dut_rst), .dut_q(dut_q)
  );

  // Narrow error counter running in lockstep on the same Q, to see saturation.
  lut_ff_mux_bist #(.ERR_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail(ff2), .dut_in(din2),
    .dut_mux_sel(sel2), .dut_rst(drst2), .dut_q(dut_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outcome from the test rules: reset check then 32 vectors.
  task automatic ref_model(input int mode, input logic [15:0] tbl, output int e, output int f);
    e = 0;
    f = 63;
    if (mode == 2) begin
      e = 1;
      f = 32;
    end
    for (int v = 0; v < 32; v++) begin
      int q, x;
      x = EXP[v / 2] ^ (v % 2);
      if (mode == 1) q = 0;
      else if (mode == 2) q = 1;
      else q = tbl[v / 2] ^ (v % 2);
      if (q != x) begin
        e++;
        if (f == 63) f = v;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".pass"}, pass, 0);
    check({tag, ".err"}, err_count, 0);
    check({tag, ".ff"}, first_fail, 63);
    check({tag, ".drst"}, dut_rst, 1);
    check({tag, ".din"}, dut_in, 0);
    check({tag, ".sel"}, dut_mux_sel, 1);
  endtask

  task automatic run(input string tag, input int mode, input logic [15:0] tbl, input bit mid_start);
    int e, f, lat, rfall;
    cell_mode = mode;
    cell_tbl  = tbl;
    ref_model(mode, tbl, e, f);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, ".busy0"}, busy, 1);
    check({tag, ".drst0"}, dut_rst, 1);
    check({tag, ".done0"}, done, 0);
    check({tag, ".clr_err"}, err_count, 0);
    check({tag, ".clr_ff"}, first_fail, 63);
    lat = 0;
    rfall = -1;
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
      if (rfall < 0 && !dut_rst) rfall = lat;
      start = mid_start && (lat == 50);
    end
    start = 1'b0;
    check({tag, ".latency"}, lat, LAT);
    check({tag, ".rst_fall"}, rfall, 10);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".pass"}, pass, (e == 0));
    check({tag, ".err"}, err_count, (e > 63) ? 63 : e);
    check({tag, ".ff"}, first_fail, f);
    check({tag, ".err4"}, err2, (e > 15) ? 15 : e);
    check({tag, ".hold_rst"}, dut_rst, 1);
    check({tag, ".hold_in"}, dut_in, 0);
    check({tag, ".hold_sel"}, dut_mux_sel, 1);
    repeat ($urandom_range(0, 4)) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("idle");

    run("good_midstart", 0, EXP, 1'b1);
    run("stuck0", 1, EXP, 1'b0);
    run("stuck1", 2, EXP, 1'b0);
    run("flip11", 0, EXP ^ 16'h0800, 1'b0);
    run("restart_good", 0, EXP, 1'b0);

    // Asynchronous reset mid-run, then a clean run.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run("after_rst", 0, EXP, 1'b0);

    for (int i = 0; i < 6; i++) begin
      int mode;
      logic [15:0] mask;
      mode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      mask = 16'($urandom) & 16'($urandom);
      run($sformatf("rand%0d", i), mode, EXP ^ mask, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lut_ff_mux_bist.md
# lut_ff_mux_bist

Synthesizable built-in self-test driver/checker for the `lut_ff_mux` cell. It sits on the far side of the cell's port list: it drives `in`, `mux_sel` and the cell's active-high `rst`, samples `Q`, and reports pass/fail so the architecture test runs on silicon or an emulator without a simulation bench. It covers three checks: the reset check, all 16 LUT inputs with `mux_sel=1`, and all 16 with `mux_sel=0`.

## Interface
Parameters:
- `SETTLE`, default 10: cycles each vector is held before `dut_q` is sampled; minimum 2.
- `RST_CYCLES`, default 10: cycles `dut_rst` is held high in the reset-check phase; minimum 2.
- `EXP_TABLE`, default 16'h6676: expected `Q` for `mux_sel=1`, bit i = input i. The `mux_sel=0` expectation is its complement.
- `ERR_W`, default 6: width of the error counter.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: a one-cycle pulse that launches a run.
- `busy` out 1: high while a run is in progress.
- `done` out 1: high from the end of a run until the next accepted `start`.
- `pass` out 1: valid while `done`; 1 when `err_count==0`.
- `err_count` out ERR_W: number of mismatches; saturates at all-ones.
- `first_fail` out 6: index of the earliest mismatch. 0–31 is a vector, 32 is the reset check, 63 means no failure.
- `dut_in` out 4: drives the cell's `in`.
- `dut_mux_sel` out 1: drives the cell's `mux_sel`.
- `dut_rst` out 1: drives the cell's active-high `rst`.
- `dut_q` in 1: the cell's `Q`.

## Operation
- FSM states: IDLE, RSTCHK, VEC, DONE.
- IDLE, or DONE, plus `start`: go to RSTCHK. On entry, clear `err_count` to 0, set `first_fail` to 63, set `done` to 0 and `busy` to 1.
- RSTCHK:
  - Hold `dut_rst=1`, `dut_in=0`, `dut_mux_sel=1` for RST_CYCLES cycles.
  - On the last cycle, expect `dut_q==0`; a mismatch is logged as index 32.
  - Then go to VEC with v=0.
- VEC, vector v = 0..31:
  - Drive `dut_rst=0`, `dut_in=v[4:1]`, `dut_mux_sel=~v[0]`. The `mux_sel=1` case comes first for each input.
  - Expected value is `EXP_TABLE[v[4:1]] ^ v[0]`.
  - Sample on the last of SETTLE cycles. On mismatch, increment `err_count` (saturating); if `first_fail==63`, load v.
  - After v=31, go to DONE.
- DONE:
  - `busy=0`, `done=1`, `pass=(err_count==0)`.
  - Hold `dut_rst=1`, `dut_in=0`, `dut_mux_sel=1`.
  - Results are held until the next `start`.
- `start` while `busy` is ignored. A run is never restarted mid-flight.
- The compare is written so an X or Z on `dut_q` counts as a mismatch: only an exact 0/1 match passes.

## Timing
- Reset values: `busy=0`, `done=0`, `pass=0`, `err_count=0`, `first_fail=63`, `dut_rst=1`, `dut_in=0`, `dut_mux_sel=1`, state IDLE.
- All outputs are registered.
- A `start` sampled at edge k gives `busy=1` and `dut_rst=1` after edge k.
- `dut_rst` falls RST_CYCLES cycles after the RSTCHK entry edge.
- Each vector's drive values change on the edge that begins its SETTLE window. `dut_q` is sampled at the edge that ends the window.
- `done` rises RST_CYCLES + 32·SETTLE cycles after RSTCHK entry. With defaults that is 330 cycles.
- `rst_n` low mid-run: immediate return to reset values and IDLE. No partial result is retained.
- `start` coincident with `rst_n` deassertion is ignored. `start` is only honoured on an edge where `rst_n` is already high.

## Structure
- Package `lut_ff_mux_bist_pkg` holds:
  - the FSM state encoding;
  - `FAIL_NONE=6'd63`, `FAIL_RST=6'd32`, `NUM_VEC=32`;
  - the default `EXP_TABLE` constant.
- One sub-module, `lut_ff_mux_bist_timer`. It is a loadable down-counter: load value, `tick` on terminal count. It is shared by the RSTCHK and VEC phases.
- The top level holds the FSM, the vector counter and the result registers.

## Test plan
- Real `lut_ff_mux` as DUT, `start` pulse → `done` after 330 cycles, `pass=1`, `err_count=0`, `first_fail=63`.
- Model with `Q` stuck at 0 → `err_count=16`, `first_fail=1`, `pass=0`.
- Model with `Q` stuck at 1 → `err_count=17`, `first_fail=32`.
- Model with the LUT bit for input 4'b1011 inverted → `err_count=2`, `first_fail=22`.
- `start` pulsed at cycle 50 of a run → ignored, `done` still at 330. Then `rst_n` low at cycle 100 of a second run → all outputs at reset values next cycle, and a new `start` completes normally.
- Restart from DONE after a failing run with the real DUT → counts cleared, `pass=1`.
